// File: rtl/keypad_pkg.sv
// Shared types, constants and small helpers for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kp_state_t;

    localparam logic [1:0] ST_SCAN     = 2'(SCAN);
    localparam logic [1:0] ST_DEBOUNCE = 2'(DEBOUNCE);
    localparam logic [1:0] ST_HELD     = 2'(HELD);

    localparam logic [3:0] COL_RESET = 4'b0001;

    // Indexed [row][col]; row 3 carries the E 0 F D layout of the physical keypad.
    localparam logic [3:0] KP_MAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    function automatic logic [3:0] rotate_col(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

endpackage

// File: rtl/keypad_hexmap.sv
// Combinational one-hot row/column to hex code lookup.
module keypad_hexmap
    import keypad_pkg::*;
(
    input  logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] hex
);

    always_comb begin
        hex = 4'h0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (row[i] && col[j]) begin
                    hex = KP_MAP[i][j];
                end
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning, debouncing 4x4 keypad front end: one pulse per accepted key, no repeat.
// Handshake: key_valid is a one-cycle strobe with key_hex stable from that cycle onward; no ready.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int DB_TICKS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] r,
    output logic [3:0] cHigh,
    output logic       key_valid,
    output logic [3:0] key_hex,
    output logic       key_held,
    output logic [1:0] state_dbg
);

    localparam int CNT_W = (DB_TICKS < 1) ? 1 : $clog2(DB_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DB_TICKS - 1);
    localparam bit ACCEPT_AT_LATCH = (DB_TICKS <= 1);

    logic [1:0]       state_q,     state_d;
    logic [3:0]       col_q,       col_d;
    logic [3:0]       row_q,       row_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [3:0]       key_hex_q,   key_hex_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q,  key_held_d;
    logic             accept;
    logic [3:0]       map_row;
    logic [3:0]       map_hex;

    // In SCAN the row is only being latched this edge, so look it up straight from r.
    assign map_row = (state_q == ST_SCAN) ? r : row_q;

    keypad_hexmap u_hexmap (
        .row (map_row),
        .col (col_q),
        .hex (map_hex)
    );

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        cnt_d       = cnt_q;
        key_hex_d   = key_hex_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        accept      = 1'b0;

        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (is_one_hot(r)) begin
                        row_d = r;
                        if (ACCEPT_AT_LATCH) begin
                            accept = 1'b1;
                        end else begin
                            cnt_d   = CNT_RELOAD;
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        col_d = rotate_col(col_q);
                    end
                end
                ST_DEBOUNCE: begin
                    // The latch tick counts as the first stable tick, so the last one accepts.
                    if (r == row_q) begin
                        if (cnt_q <= CNT_W'(1)) begin
                            accept = 1'b1;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end else begin
                        col_d   = rotate_col(col_q);
                        state_d = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (r == 4'b0000) begin
                        if (cnt_q == '0) begin
                            key_held_d = 1'b0;
                            col_d      = rotate_col(col_q);
                            state_d    = ST_SCAN;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end else begin
                        cnt_d = CNT_RELOAD;
                    end
                end
                default: begin
                    state_d = ST_SCAN;
                    col_d   = COL_RESET;
                end
            endcase
        end

        if (accept) begin
            key_hex_d   = map_hex;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            cnt_d       = CNT_RELOAD;
            state_d     = ST_HELD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SCAN;
            col_q       <= COL_RESET;
            row_q       <= 4'b0000;
            cnt_q       <= '0;
            key_hex_q   <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            key_hex_q   <= key_hex_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign cHigh     = col_q;
    assign key_valid = key_valid_q;
    assign key_hex   = key_hex_q;
    assign key_held  = key_held_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed scenarios then random row traffic vs a tick-level model.
module tb_keypad_scanner;

    localparam int DB_TICKS = 3;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [3:0] r;
    logic [3:0] c_high;
    logic       key_valid;
    logic [3:0] key_hex;
    logic       key_held;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    keypad_scanner #(.DB_TICKS(DB_TICKS)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .r         (r),
        .cHigh     (c_high),
        .key_valid (key_valid),
        .key_hex   (key_hex),
        .key_held  (key_held),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks column index and run lengths of stable ticks counted upward.
    logic [3:0] hex_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC,
                                 4'hE, 4'h0, 4'hF, 4'hD};
    int         m_col;
    int         m_press_run;
    int         m_zero_run;
    logic [3:0] m_cand;
    logic       m_held;
    logic [3:0] m_hex;
    logic       m_pulse;

    task automatic model_reset();
        m_col       = 0;
        m_press_run = 0;
        m_zero_run  = 0;
        m_cand      = 4'b0000;
        m_held      = 1'b0;
        m_hex       = 4'h0;
        m_pulse     = 1'b0;
    endtask

    task automatic model_tick(input logic [3:0] rv);
        int row_idx;
        m_pulse = 1'b0;
        if (m_held) begin
            if (rv == 4'b0000) begin
                m_zero_run++;
                if (m_zero_run == DB_TICKS) begin
                    m_held = 1'b0;
                    m_col  = (m_col + 1) % 4;
                end
            end else begin
                m_zero_run = 0;
            end
        end else if (m_press_run > 0) begin
            if (rv == m_cand) begin
                m_press_run++;
            end else begin
                m_press_run = 0;
                m_col       = (m_col + 1) % 4;
            end
        end else if ($countones(rv) == 1) begin
            m_cand      = rv;
            m_press_run = 1;
        end else begin
            m_col = (m_col + 1) % 4;
        end

        if (!m_held && m_press_run >= DB_TICKS) begin
            row_idx = 0;
            for (int i = 0; i < 4; i++) begin
                if (m_cand[i]) row_idx = i;
            end
            m_hex       = hex_tab[row_idx * 4 + m_col];
            m_held      = 1'b1;
            m_zero_run  = 0;
            m_press_run = 0;
            m_pulse     = 1'b1;
            exp_q.push_back(m_hex);
        end
    endtask

    function automatic logic [1:0] model_state();
        if (m_held) return 2'd2;
        if (m_press_run > 0) return 2'd1;
        return 2'd0;
    endfunction

    // ---------------- driver tasks ----------------
    // One tick edge: drive, clock, then compare every output against the model.
    task automatic tick_edge(input logic [3:0] rv);
        logic [3:0] exp_hex;
        r    = rv;
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        model_tick(rv);
        check_eq("key_valid", key_valid, m_pulse);
        if (key_valid) begin
            check_eq("pulse_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                exp_hex = exp_q.pop_front();
                check_eq("pulse_hex", key_hex, exp_hex);
            end
        end
        check_eq("cHigh", c_high, 4'b0001 << m_col);
        check_eq("key_hex", key_hex, m_hex);
        check_eq("key_held", key_held, m_held);
        check_eq("state", state_dbg, model_state());
    endtask

    task automatic do_tick(input logic [3:0] rv);
        tick_edge(rv);
        @(posedge clk);
        #1;
        check_eq("valid_clear", key_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] rv, input logic tk);
        reset = 1'b1;
        tick  = tk;
        r     = rv;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick  = 1'b0;
        r     = 4'b0000;
        model_reset();
        exp_q.delete();
        check_eq("rst_cHigh", c_high, 4'b0001);
        check_eq("rst_valid", key_valid, 1'b0);
        check_eq("rst_hex", key_hex, 4'h0);
        check_eq("rst_held", key_held, 1'b0);
        check_eq("rst_state", state_dbg, 2'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_no_pulse", key_valid, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] v;
        int         run;
        reset = 1'b1;
        tick  = 1'b0;
        r     = 4'b0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset(4'b0000, 1'b0);

        // Idle rotation wraps back to column 0 after eight ticks.
        repeat (8) do_tick(4'b0000);
        check_eq("idle_wrap", c_high, 4'b0001);

        // Press row 1 at column 2 for DB_TICKS ticks -> hex 6.
        repeat (2) do_tick(4'b0000);
        repeat (3) do_tick(4'b0010);
        check_eq("t2_hex", key_hex, 4'h6);
        check_eq("t2_held", key_held, 1'b1);
        check_eq("t2_col", c_high, 4'b0100);

        // Release interrupted by a bounce; only the final run of zeros releases.
        repeat (2) do_tick(4'b0000);
        do_tick(4'b0001);
        repeat (2) do_tick(4'b0000);
        check_eq("t4_still_held", key_held, 1'b1);
        do_tick(4'b0000);
        check_eq("t4_released", key_held, 1'b0);
        check_eq("t4_next_col", c_high, 4'b1000);

        // Single-tick bounce at column 0 abandons and moves on.
        do_tick(4'b0000);
        do_tick(4'b0001);
        do_tick(4'b0000);
        check_eq("t3_col", c_high, 4'b0010);
        check_eq("t3_state", state_dbg, 2'd0);

        // Ghosting pattern never latches.
        repeat (4) do_tick(4'b0101);
        check_eq("t5_col", c_high, 4'b0010);
        check_eq("t5_held", key_held, 1'b0);

        // Reset during debounce with a tick present: tick ignored.
        do_tick(4'b0100);
        do_reset(4'b0100, 1'b1);

        // Reset on the key_valid cycle: pulse cut, nothing emitted later.
        repeat (2) do_tick(4'b1000);
        tick_edge(4'b1000);
        do_reset(4'b1000, 1'b0);

        // Random traffic: runs of a value so presses both complete and bounce.
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: v = 4'b0000;
                4, 5, 6, 7: v = 4'(4'b0001 << $urandom_range(0, 3));
                default:    v = 4'($urandom_range(0, 15));
            endcase
            run = $urandom_range(1, 5);
            for (int t = 0; t < run; t++) begin
                do_tick(v);
            end
            if ($urandom_range(0, 39) == 0) begin
                do_reset(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end
        end

        check_eq("exp_q_drained", exp_q.size() == 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
